// File: rtl/unidad_control_multiciclo.sv
// Multi-cycle control unit for a MIPS-like datapath.
// Moore outputs come from the state; IRWrite/PCWrite in FETCH also depend on mem_ready.
module unidad_control_multiciclo (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] OpCode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       JumpAndLink,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic [1:0] BranchType,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  state_t     state_q, state_d;
  // Branch kind is latched in DECODE so BRANCH never looks at OpCode.
  logic [1:0] br_type_q, br_type_d;

  // State and latched branch kind registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      br_type_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      br_type_q <= br_type_d;
    end
  end

  assign state = state_q;

  // Next-state and control output decode.
  always_comb begin
    state_d     = state_q;
    br_type_d   = br_type_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    JumpAndLink = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 3'b000;
    BranchType  = 2'b00;
    illegal_op  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // Strobes are held off while reset is asserted.
        IRWrite = mem_ready & reset_n;
        PCWrite = mem_ready & reset_n;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (OpCode)
          OP_R:                               state_d = S_R_EXEC;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_I_EXEC;
          OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
          OP_BEQ:  begin state_d = S_BRANCH; br_type_d = 2'b00; end
          OP_BNE:  begin state_d = S_BRANCH; br_type_d = 2'b01; end
          OP_BGTZ: begin state_d = S_BRANCH; br_type_d = 2'b10; end
          OP_J:                               state_d = S_JUMP;
          OP_JAL:                             state_d = S_JAL;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (OpCode == OP_SW) begin
          state_d = S_MEM_WR;
        end else if (OpCode == OP_LW) begin
          state_d = S_MEM_RD;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEM_WR;
        end
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (OpCode)
          OP_ANDI: ALUOp = 3'b100;
          OP_ORI:  ALUOp = 3'b101;
          OP_SLTI: ALUOp = 3'b111;
          default: ALUOp = 3'b000;
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchType  = br_type_q;
        if (br_type_q == 2'b10) begin
          ALUOp = 3'b110;
        end else begin
          ALUOp = 3'b001;
        end
        state_d = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        PCWrite     = 1'b1;
        PCSource    = 2'b10;
        RegWrite    = 1'b1;
        JumpAndLink = 1'b1;
        state_d     = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares the packed control word.
module tb_unidad_control_multiciclo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] OpCode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemToReg, RegWrite, ALUSrcA, JumpAndLink;
  logic [1:0] ALUSrcB, PCSource, BranchType;
  logic [2:0] ALUOp;
  logic [3:0] state;
  logic       illegal_op;

  always #5 clk = ~clk;

  unidad_control_multiciclo dut (
    .clk(clk), .reset_n(reset_n), .OpCode(OpCode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .JumpAndLink(JumpAndLink),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .BranchType(BranchType),
    .state(state), .illegal_op(illegal_op)
  );

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
  //  RegDst, MemToReg, RegWrite, ALUSrcA, JumpAndLink, ALUSrcB, PCSource, ALUOp, BranchType, illegal_op}
  logic [24:0] act;
  assign act = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                RegDst, MemToReg, RegWrite, ALUSrcA, JumpAndLink,
                ALUSrcB, PCSource, ALUOp, BranchType, illegal_op};

  logic [24:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [24:0] pk(input logic [3:0] st, input logic [10:0] strb,
                                     input logic [1:0] asb, input logic [1:0] pcs,
                                     input logic [2:0] aluop, input logic [1:0] bt,
                                     input logic ill);
    return {st, strb, asb, pcs, aluop, bt, ill};
  endfunction

  function automatic logic [24:0] e_fetch(input logic mr);
    return pk(4'd0, {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 5'b00000}, 2'b01, 2'b00, 3'b000, 2'b00, 1'b0);
  endfunction
  function automatic logic [24:0] e_decode(input logic ill);
    return pk(4'd1, 11'b00000000000, 2'b11, 2'b00, 3'b000, 2'b00, ill);
  endfunction
  function automatic logic [24:0] e_iexec(input logic [2:0] aluop);
    return pk(4'd8, 11'b00000000010, 2'b10, 2'b00, aluop, 2'b00, 1'b0);
  endfunction
  function automatic logic [24:0] e_branch(input logic [2:0] aluop, input logic [1:0] bt);
    return pk(4'd10, 11'b01000000010, 2'b00, 2'b01, aluop, bt, 1'b0);
  endfunction

  logic [24:0] E_MEMADDR, E_MEMRD, E_MEMWB, E_MEMWR, E_REXEC, E_RWB, E_IWB, E_JUMP, E_JAL, E_FETCH_RST;
  initial begin
    E_MEMADDR   = pk(4'd2,  11'b00000000010, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0);
    E_MEMRD     = pk(4'd3,  11'b00110000000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0);
    E_MEMWB     = pk(4'd4,  11'b00000001100, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0);
    E_MEMWR     = pk(4'd5,  11'b00101000000, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0);
    E_REXEC     = pk(4'd6,  11'b00000000010, 2'b00, 2'b00, 3'b010, 2'b00, 1'b0);
    E_RWB       = pk(4'd7,  11'b00000010100, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0);
    E_IWB       = pk(4'd9,  11'b00000000100, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0);
    E_JUMP      = pk(4'd11, 11'b10000000000, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0);
    E_JAL       = pk(4'd12, 11'b10000000101, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0);
    E_FETCH_RST = pk(4'd0,  11'b00010000000, 2'b01, 2'b00, 3'b000, 2'b00, 1'b0);
  end

  task automatic push(input logic [24:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input logic [5:0] op, input logic mr, input logic [24:0] e, input string nm);
    @(posedge clk);
    #1;
    OpCode    = op;
    mem_ready = mr;
    push(e, nm);
  endtask

  // Monitor: one expectation per cycle, compared away from the rising edge.
  initial begin
    logic [24:0] e;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", nm, act, e);
        end
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    OpCode    = OP_R;
    #1;
    push(E_FETCH_RST, "reset_state");
    @(negedge clk);
    #2;
    reset_n   = 1'b1;
    mem_ready = 1'b0;
    step(OP_BAD, 1'b0, e_fetch(1'b0), "post_reset_wait");

    // lw, with OpCode disturbed in states that must ignore it
    step(OP_BAD, 1'b1, e_fetch(1'b1), "lw_fetch");
    step(OP_LW,  1'b1, e_decode(1'b0), "lw_decode");
    step(OP_LW,  1'b1, E_MEMADDR, "lw_addr");
    step(OP_SW,  1'b1, E_MEMRD, "lw_rd");
    step(OP_R,   1'b1, E_MEMWB, "lw_wb");

    // sw with three stall cycles
    step(OP_SW, 1'b1, e_fetch(1'b1), "sw_fetch");
    step(OP_SW, 1'b1, e_decode(1'b0), "sw_decode");
    step(OP_SW, 1'b1, E_MEMADDR, "sw_addr");
    for (int i = 0; i < 3; i++) step(OP_SW, 1'b0, E_MEMWR, "sw_wr_stall");
    step(OP_LW, 1'b1, E_MEMWR, "sw_wr_done");

    // R-type with a stalled fetch
    step(OP_R, 1'b0, e_fetch(1'b0), "r_fetch_stall");
    step(OP_R, 1'b1, e_fetch(1'b1), "r_fetch");
    step(OP_R, 1'b1, e_decode(1'b0), "r_decode");
    step(OP_R, 1'b1, E_REXEC, "r_exec");
    step(OP_R, 1'b1, E_RWB, "r_wb");

    step(OP_ORI, 1'b1, e_fetch(1'b1), "ori_fetch");
    step(OP_ORI, 1'b1, e_decode(1'b0), "ori_decode");
    step(OP_ORI, 1'b1, e_iexec(3'b101), "ori_exec");
    step(OP_ORI, 1'b1, E_IWB, "ori_wb");

    step(OP_SLTI, 1'b1, e_fetch(1'b1), "slti_fetch");
    step(OP_SLTI, 1'b1, e_decode(1'b0), "slti_decode");
    step(OP_SLTI, 1'b1, e_iexec(3'b111), "slti_exec");
    step(OP_SLTI, 1'b1, E_IWB, "slti_wb");

    // bne: OpCode changed to bgtz in BRANCH must not alter it
    step(OP_BNE,  1'b1, e_fetch(1'b1), "bne_fetch");
    step(OP_BNE,  1'b1, e_decode(1'b0), "bne_decode");
    step(OP_BGTZ, 1'b1, e_branch(3'b001, 2'b01), "bne_branch");

    step(OP_BGTZ, 1'b1, e_fetch(1'b1), "bgtz_fetch");
    step(OP_BGTZ, 1'b1, e_decode(1'b0), "bgtz_decode");
    step(OP_BGTZ, 1'b1, e_branch(3'b110, 2'b10), "bgtz_branch");

    step(OP_BEQ, 1'b1, e_fetch(1'b1), "beq_fetch");
    step(OP_BEQ, 1'b1, e_decode(1'b0), "beq_decode");
    step(OP_BEQ, 1'b1, e_branch(3'b001, 2'b00), "beq_branch");

    step(OP_J, 1'b1, e_fetch(1'b1), "j_fetch");
    step(OP_J, 1'b1, e_decode(1'b0), "j_decode");
    step(OP_J, 1'b1, E_JUMP, "j_jump");

    step(OP_BAD, 1'b1, e_fetch(1'b1), "ill_fetch");
    step(OP_BAD, 1'b1, e_decode(1'b1), "ill_decode");

    // reset dropped between edges while in R_EXEC
    step(OP_R, 1'b1, e_fetch(1'b1), "rst_r_fetch");
    step(OP_R, 1'b1, e_decode(1'b0), "rst_r_decode");
    step(OP_R, 1'b1, E_REXEC, "rst_r_exec");
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got state=%0d RegWrite=%b expected state=0 RegWrite=0", state, RegWrite);
    end
    step(OP_R, 1'b1, E_FETCH_RST, "rst_hold");
    @(negedge clk);
    #2;
    reset_n   = 1'b1;
    mem_ready = 1'b0;
    step(OP_R, 1'b0, e_fetch(1'b0), "rst_resume_wait");

    step(OP_JAL, 1'b1, e_fetch(1'b1), "jal_fetch");
    step(OP_JAL, 1'b1, e_decode(1'b0), "jal_decode");
    step(OP_JAL, 1'b1, E_JAL, "jal_jal");
    step(OP_R,   1'b0, e_fetch(1'b0), "jal_back_fetch");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unidad_control_multiciclo.md
UNIDAD_CONTROL_MULTICICLO -- requirements
Module: unidad_control_multiciclo

Interface
REQ-001 Block SHALL have no parameters.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 OpCode  in  6  instruction opcode, valid from the cycle after IR is written.
REQ-005 mem_ready  in  1  memory handshake; the access in progress completes in the cycle this is 1.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite  out  1 each  PC and memory controls.
REQ-007 RegDst, MemToReg, RegWrite, ALUSrcA, JumpAndLink  out  1 each  register file and ALU source controls.
REQ-008 ALUSrcB  out  2  ALU B select: 00 reg B, 01 const 4, 10 sign-extended immediate, 11 immediate shifted left 2.
REQ-009 PCSource  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-010 ALUOp  out  3  same encoding as the single-cycle unit: 000 add, 001 sub, 010 funct, 100 and, 101 or, 110 bgtz, 111 slt.
REQ-011 BranchType  out  2  branch condition: 00 beq, 01 bne, 10 bgtz.
REQ-012 state  out  4  current state encoding, for debug.
REQ-013 illegal_op  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-014 States and encoding SHALL be: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11, JAL 12.
REQ-015 Outputs SHALL default to 0 in every state unless listed below.
REQ-016 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00.
  - IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1; the FSM then goes to DECODE.
  - While mem_ready=0, FSM stays in FETCH.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000. Next state by OpCode:
  - 000000 -> R_EXEC
  - 001000/001100/001101/001010 -> I_EXEC
  - 100011/101011 -> MEM_ADDR
  - 000100/000101/000111 -> BRANCH
  - 000010 -> JUMP
  - 000011 -> JAL
  - any other -> FETCH, with illegal_op=1 in that DECODE cycle.
REQ-018 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next state MEM_RD for lw, MEM_WR for sw.
REQ-019 MEM_RD: MemRead=1, IorD=1. Holds until mem_ready=1, then goes to MEM_WB.
REQ-020 MEM_WB: RegWrite=1, MemToReg=1, RegDst=0. Next state FETCH.
REQ-021 MEM_WR: MemWrite=1, IorD=1. Holds until mem_ready=1, then goes to FETCH.
REQ-022 R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next state R_WB.
REQ-023 R_WB: RegWrite=1, RegDst=1. Next state FETCH.
REQ-024 I_EXEC: ALUSrcA=1, ALUSrcB=10. ALUOp SHALL be 000 addi, 100 andi, 101 ori, 111 slti. Next state I_WB.
REQ-025 I_WB: RegWrite=1, RegDst=0. Next state FETCH.
REQ-026 BRANCH: ALUSrcA=1, ALUSrcB=00, PCWriteCond=1, PCSource=01.
  - ALUOp SHALL be 001 for beq/bne and 110 for bgtz.
  - BranchType SHALL be 00/01/10 for beq/bne/bgtz.
  - Next state FETCH.
REQ-027 JUMP: PCWrite=1, PCSource=10. Next state FETCH.
REQ-028 JAL: PCWrite=1, PCSource=10, RegWrite=1, JumpAndLink=1. Next state FETCH.
REQ-029 OpCode SHALL be sampled only in DECODE, MEM_ADDR and I_EXEC; OpCode changes in other states SHALL have no effect.
REQ-030 MemRead and MemWrite SHALL never be 1 in the same cycle.
REQ-031 Unused state encodings 13-15 SHALL go to FETCH on the next edge with all outputs 0.
REQ-032 Per-instruction latency with mem_ready tied to 1:
  - lw 5 cycles
  - sw, R-type, I-type 4 cycles
  - beq/bne/bgtz, j, jal 3 cycles
  - each extra mem_ready=0 cycle adds exactly 1.

Reset
REQ-033 When reset_n=0, state SHALL become FETCH immediately, independent of clk, and all outputs except FETCH's Moore outputs SHALL be 0.
REQ-034 Reset asserted mid-instruction (including during a stalled MEM_WR) SHALL abort it, with no further PCWrite, RegWrite or MemWrite pulses.
REQ-035 After reset_n rises, the first FETCH access SHALL begin on the next rising edge.

Verification
REQ-036 lw (100011), mem_ready=1 -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemToReg=1 only in state 4.
REQ-037 sw with mem_ready=0 for 3 cycles in MEM_WR -> MemWrite=1 held 4 cycles, then state 0; no RegWrite.
REQ-038 bgtz (000111) -> in state 10: ALUOp=110, BranchType=10, PCWriteCond=1, PCSource=01.
REQ-039 jal (000011) -> state 12 with PCWrite=1, RegWrite=1, JumpAndLink=1, PCSource=10; then state 0.
REQ-040 OpCode 111111 -> illegal_op pulses 1 cycle in DECODE; next state 0; no write strobes.
REQ-041 reset_n dropped between edges while in R_EXEC -> state=0 immediately; RegWrite stays 0; fetch resumes after reset_n=1.
